// File: rtl/alst4_sw_debounce.sv
// Purpose : debounces SW_W raw dip-switch pins with a 2-flop synchronizer and a per-bit stable-level qualifier.
// Latency : a clean level change reaches usr_sw_o DEB_CYCLES+1 edges after the edge that captures it into s1.
// Backpr. : none; this is a free-running sampler with no flow control.
//
// Ports:
//   sys0_clk     - single clock, all state on its rising edge
//   sys0_rstn    - asynchronous active-low reset
//   usr_sw_i     - raw, asynchronous, bouncing switch levels
//   usr_sw_o     - debounced switch levels
//   sw_chg       - one-cycle strobe, first cycle a new usr_sw_o value is visible
//   sw_chg_mask  - which usr_sw_o bits changed in the sw_chg cycle
//   sw_evt_cnt   - number of sw_chg strobes since reset (wraps)
//   sw_stable    - high when no bit has a qualification in progress
module alst4_sw_debounce #(
  parameter int              SW_W       = 8,
  parameter int              DEB_CYCLES = 200000,
  parameter logic [SW_W-1:0] RST_VAL    = '0
) (
  input  logic            sys0_clk,
  input  logic            sys0_rstn,
  input  logic [SW_W-1:0] usr_sw_i,
  output logic [SW_W-1:0] usr_sw_o,
  output logic            sw_chg,
  output logic [SW_W-1:0] sw_chg_mask,
  output logic [15:0]     sw_evt_cnt,
  output logic            sw_stable
);

  // Counter wide enough to hold DEB_CYCLES, never narrower than one bit.
  localparam int              CNT_W    = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  sync1_q;
  logic [SW_W-1:0]  sync2_q;
  logic [SW_W-1:0]  sw_q,     sw_d;
  logic [CNT_W-1:0] cnt_q [SW_W];
  logic [CNT_W-1:0] cnt_d [SW_W];
  logic [SW_W-1:0]  upd;
  logic             chg_q;
  logic [SW_W-1:0]  mask_q;
  logic [15:0]      evt_q,    evt_d;
  logic             stable_q, stable_d;
  logic             cnt_idle;

  // Per-bit qualifier. Only the synchronized level is ever compared; any
  // return to the output level wipes the count so no partial credit survives.
  always_comb begin
    upd      = '0;
    cnt_idle = 1'b1;
    for (int b = 0; b < SW_W; b++) begin
      cnt_d[b] = '0;
      if (cnt_q[b] != '0) begin
        cnt_idle = 1'b0;
      end
      if (sync2_q[b] != sw_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          upd[b] = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
    sw_d     = (sw_q & ~upd) | (sync2_q & upd);
    evt_d    = (|upd) ? evt_q + 16'd1 : evt_q;
    // Reflects the state present at this edge, not the state after it.
    stable_d = cnt_idle && (sync2_q == sw_q);
  end

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      sync1_q  <= RST_VAL;
      sync2_q  <= RST_VAL;
      sw_q     <= RST_VAL;
      chg_q    <= 1'b0;
      mask_q   <= '0;
      evt_q    <= '0;
      stable_q <= 1'b0;
      for (int b = 0; b < SW_W; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      sync1_q  <= usr_sw_i;
      sync2_q  <= sync1_q;
      sw_q     <= sw_d;
      chg_q    <= |upd;
      mask_q   <= upd;
      evt_q    <= evt_d;
      stable_q <= stable_d;
      for (int b = 0; b < SW_W; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign usr_sw_o    = sw_q;
  assign sw_chg      = chg_q;
  assign sw_chg_mask = mask_q;
  assign sw_evt_cnt  = evt_q;
  assign sw_stable   = stable_q;

endmodule

// File: tb/tb_alst4_sw_debounce.sv
// Bench for alst4_sw_debounce (SW_W=8, DEB_CYCLES=4, RST_VAL=0).
// A history-based reference model predicts every update event; a monitor on
// the falling edge checks strobes against a queue and levels every cycle.
module tb_alst4_sw_debounce;

  localparam int SW_W = 8;
  localparam int DEB  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  sw_in = 8'h00;
  logic [7:0]  usr_sw_o;
  logic        sw_chg;
  logic [7:0]  sw_chg_mask;
  logic [15:0] sw_evt_cnt;
  logic        sw_stable;

  alst4_sw_debounce #(
    .SW_W      (SW_W),
    .DEB_CYCLES(DEB),
    .RST_VAL   (8'h00)
  ) dut (
    .sys0_clk   (clk),
    .sys0_rstn  (rst_n),
    .usr_sw_i   (sw_in),
    .usr_sw_o   (usr_sw_o),
    .sw_chg     (sw_chg),
    .sw_chg_mask(sw_chg_mask),
    .sw_evt_cnt (sw_evt_cnt),
    .sw_stable  (sw_stable)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  out;
    logic [7:0]  mask;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  in_hist[$];   // raw input sampled at edge n (n counted from reset release)
  int          n_edge;
  int          last_upd[8];  // edge of each bit's most recent update, -1 if none
  logic [7:0]  m_out;
  logic [15:0] m_cnt;
  logic        m_stable;
  int          total_evts;

  // Synchronized level seen just before edge n: the input two samples earlier.
  function automatic logic [7:0] s2_at(input int n);
    return (n >= 2) ? in_hist[n-2] : 8'h00;
  endfunction

  // Consecutive edges ending at n_end (after the bit's last update) on which
  // the synchronized level disagreed with the current output, capped at DEB.
  function automatic int run_len(input int b, input int n_end);
    int r = 0;
    int j = n_end;
    logic [7:0] v;
    while (j >= 0 && j > last_upd[b] && r < DEB) begin
      v = s2_at(j);
      if (v[b] == m_out[b]) break;
      r++;
      j--;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_hist.delete();
      exp_q.delete();
      n_edge     = 0;
      m_out      = 8'h00;
      m_cnt      = 16'h0000;
      m_stable   = 1'b0;
      total_evts = 0;
      for (int b = 0; b < 8; b++) last_upd[b] = -1;
    end else begin
      logic [7:0] mask;
      logic       st;
      exp_t       e;
      in_hist.push_back(sw_in);
      st = (s2_at(n_edge) == m_out);
      for (int b = 0; b < 8; b++) if (run_len(b, n_edge - 1) != 0) st = 1'b0;
      mask = 8'h00;
      for (int b = 0; b < 8; b++) if (run_len(b, n_edge) >= DEB) mask[b] = 1'b1;
      for (int b = 0; b < 8; b++) if (mask[b]) last_upd[b] = n_edge;
      m_out = m_out ^ mask;
      if (mask != 8'h00) begin
        m_cnt = m_cnt + 16'd1;
        total_evts++;
        e.out  = m_out;
        e.mask = mask;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
      end
      m_stable = st;
      n_edge++;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {7'b0, sw_stable, sw_evt_cnt, sw_chg_mask[6:0], sw_chg} ^ {8'b0, usr_sw_o, 16'b0}, 32'h0);
      chk("reset_mask_msb", 32'(sw_chg_mask[7]), 32'h0);
    end else begin
      chk("usr_sw_o", 32'(usr_sw_o), 32'(m_out));
      chk("sw_stable", 32'(sw_stable), 32'(m_stable));
      chk("sw_evt_cnt", 32'(sw_evt_cnt), 32'(m_cnt));
      if (sw_chg) begin
        if (exp_q.size() == 0) begin
          chk("spurious_sw_chg", 32'(sw_chg), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_out", 32'(usr_sw_o), 32'(e.out));
          chk("strobe_mask", 32'(sw_chg_mask), 32'(e.mask));
          chk("strobe_cnt", 32'(sw_evt_cnt), 32'(e.cnt));
        end
      end else begin
        chk("idle_mask", 32'(sw_chg_mask), 32'h0);
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          chk("missing_sw_chg", 32'(sw_chg), 32'h1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    #1 sw_in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Falling edges until sw_chg is seen, bounded; 99 marks a timeout.
  task automatic wait_chg(output int k);
    int found = 0;
    k = 0;
    while (!found && k < 20) begin
      @(negedge clk);
      k++;
      if (sw_chg) found = 1;
    end
    if (!found) k = 99;
  endtask

  initial begin
    int lat;
    int guard;
    rst_n = 1'b0;
    sw_in = 8'h00;
    idle(3);
    #1 rst_n = 1'b1;

    // Quiet switches after reset: settles to stable, never strobes.
    idle(10);
    chk("stable_after_reset", 32'(sw_stable), 32'h1);

    // Two bits change together: one strobe, both mask bits, E+5 latency.
    drive(8'h81);
    wait_chg(lat);
    chk("latency_81", 32'(lat), 32'd6);
    chk("mask_81", 32'(sw_chg_mask), 32'h81);
    idle(1);
    chk("strobe_one_cycle", 32'(sw_chg), 32'h0);
    chk("cnt_after_81", 32'(sw_evt_cnt), 32'd1);
    drive(8'h00);
    idle(10);

    // Three-cycle glitch on bit 3 is rejected.
    drive(8'h08);
    idle(2);
    drive(8'h00);
    idle(10);
    chk("glitch_out", 32'(usr_sw_o), 32'h00);
    chk("glitch_stable", 32'(sw_stable), 32'h1);

    // Staggered bits produce separate strobes two cycles apart.
    drive(8'h01);
    idle(1);
    drive(8'h03);
    idle(10);
    drive(8'h00);
    idle(10);

    // Reset two cycles into a bit-7 qualification, then requalify after release.
    drive(8'h80);
    idle(2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_abort_out", 32'(usr_sw_o), 32'h00);
    chk("rst_abort_cnt", 32'(sw_evt_cnt), 32'h0);
    idle(2);
    #1 rst_n = 1'b1;
    wait_chg(lat);
    chk("latency_after_reset", 32'(lat), 32'd6);
    chk("mask_after_reset", 32'(sw_chg_mask), 32'h80);
    idle(8);

    // Random bouncing: single-bit flips with random hold, occasional multi-bit.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) sw_in = sw_in ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) sw_in = sw_in ^ 8'($urandom_range(0, 255));
    end
    idle(12);

    // Drive the event counter to its wrap: staggered toggles give ~1 strobe/cycle.
    guard = 0;
    while (total_evts < 65500 && guard < 80000) begin
      @(negedge clk);
      #1 sw_in = sw_in ^ 8'(1 << (guard % 8));
      guard++;
    end
    idle(12);
    guard = 0;
    while (total_evts < 65535 && guard < 200) begin
      drive(sw_in ^ 8'h01);
      idle(8);
      guard++;
    end
    chk("cnt_at_ffff", 32'(sw_evt_cnt), 32'h0000FFFF);
    drive(sw_in ^ 8'h01);
    wait_chg(lat);
    chk("wrap_latency", 32'(lat), 32'd6);
    chk("cnt_wrapped", 32'(sw_evt_cnt), 32'h0);
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule
